// File: rtl/xadc_drp_config.sv
// xadc_drp_config: DRP initiator for xadc_wiz_0.
// After reset it writes a 4-entry configuration table over DRP, then reads
// the converted result of the configured aux channel on every matching
// end-of-conversion and presents it as a 12-bit sample.
// Optional build macro: XADC_READBACK_VERIFY_EN adds a read-back compare
// after every configuration write (8 DRP transactions per config pass).
//
// state       | meaning
// ------------+----------------------------------------------------------
// WR_REQ      | issue DRP write of table[idx] (den+dwe for one cycle)
// WR_WAIT     | wait for drdy of the write, addr/data held
// VF_REQ      | issue read-back of table[idx] address (verify build only)
// VF_WAIT     | wait for read-back drdy and compare (verify build only)
// RUN         | configured; watch eoc for the aux channel
// RD_WAIT     | wait for drdy of the sample read
// ERR         | timeout or verify mismatch; DRP idle until restart
module xadc_drp_config #(
  parameter logic [15:0] CFG_REG0 = 16'h9000,
  parameter logic [15:0] CFG_REG1 = 16'h2000,
  parameter logic [15:0] CFG_REG2 = 16'h0400,
  parameter int unsigned AUX_CH   = 3,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        eoc_in,
  input  logic [4:0]  channel_in,
  input  logic        drdy_in,
  input  logic [15:0] do_in,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        cfg_done,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_WR_REQ  = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_RUN     = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ERR     = 3'd4,
    ST_VF_REQ  = 3'd5,
    ST_VF_WAIT = 3'd6
  } state_t;

  localparam logic [4:0]  AUX_CHAN = 5'(16 + AUX_CH);
  localparam logic [7:0]  TMO      = 8'(TIMEOUT);
  localparam logic [15:0] AUX_MASK = 16'h0001 << AUX_CH;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [11:0] sample_q, sample_d;
  logic        sv_q, sv_d;
  logic        pend_q, pend_d;
  logic        go_q;

  logic [6:0]  tbl_addr;
  logic [15:0] tbl_data;
  state_t      adv_state;
  logic [1:0]  adv_idx;
  logic        restart_now;
  logic        timeout_hit;
  logic        unused_do;

  // Low nibble of DRP read data is below the 12-bit ADC resolution.
  assign unused_do   = ^do_in[3:0];
  assign restart_now = pend_q | restart;
  assign timeout_hit = (cnt_q == TMO);

  // Configuration table lookup by index.
  always_comb begin
    tbl_addr = 7'h00;
    tbl_data = 16'h0000;
    case (idx_q)
      2'd0: begin tbl_addr = 7'h40; tbl_data = CFG_REG0; end
      2'd1: begin tbl_addr = 7'h41; tbl_data = CFG_REG1; end
      2'd2: begin tbl_addr = 7'h42; tbl_data = CFG_REG2; end
      default: begin tbl_addr = 7'h49; tbl_data = AUX_MASK; end
    endcase
  end

  // Where a completed config entry leads: deferred restart, next entry, or RUN.
  always_comb begin
    adv_state = ST_WR_REQ;
    adv_idx   = idx_q;
    if (restart_now) begin
      adv_idx = 2'd0;
    end else if (idx_q == 2'd3) begin
      adv_state = ST_RUN;
    end else begin
      adv_idx = idx_q + 2'd1;
    end
  end

  // Next-state and DRP output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    sample_d  = sample_q;
    sv_d      = 1'b0;
    pend_d    = restart_now;
    den_out   = 1'b0;
    dwe_out   = 1'b0;
    daddr_out = 7'h00;
    di_out    = 16'h0000;

    case (state_q)
      ST_WR_REQ: begin
        // go_q keeps the port quiet in the first cycle after reset release
        if (go_q) begin
          den_out   = 1'b1;
          dwe_out   = 1'b1;
          daddr_out = tbl_addr;
          di_out    = tbl_data;
          cnt_d     = 8'd0;
          state_d   = ST_WR_WAIT;
        end
      end

      ST_WR_WAIT: begin
        daddr_out = tbl_addr;
        di_out    = tbl_data;
        cnt_d     = cnt_q + 8'd1;
        if (drdy_in) begin
`ifdef XADC_READBACK_VERIFY_EN
          state_d = ST_VF_REQ;
`else
          state_d = adv_state;
          idx_d   = adv_idx;
          pend_d  = 1'b0;
`endif
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end

`ifdef XADC_READBACK_VERIFY_EN
      ST_VF_REQ: begin
        den_out   = 1'b1;
        daddr_out = tbl_addr;
        cnt_d     = 8'd0;
        state_d   = ST_VF_WAIT;
      end

      ST_VF_WAIT: begin
        daddr_out = tbl_addr;
        cnt_d     = cnt_q + 8'd1;
        if (drdy_in) begin
          if (do_in != tbl_data) begin
            state_d = ST_ERR;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
            pend_d  = 1'b0;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end
`endif

      ST_RUN: begin
        pend_d = 1'b0;
        if (restart) begin
          idx_d   = 2'd0;
          state_d = ST_WR_REQ;
        end else if (eoc_in && (channel_in == AUX_CHAN)) begin
          den_out   = 1'b1;
          daddr_out = {2'b00, channel_in};
          rd_addr_d = channel_in;
          cnt_d     = 8'd0;
          state_d   = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        daddr_out = {2'b00, rd_addr_q};
        cnt_d     = cnt_q + 8'd1;
        if (drdy_in) begin
          sample_d = do_in[15:4];
          sv_d     = 1'b1;
          pend_d   = 1'b0;
          if (restart_now) begin
            idx_d   = 2'd0;
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RUN;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR;
        end
      end

      ST_ERR: begin
        pend_d = 1'b0;
        if (restart_now) begin
          idx_d   = 2'd0;
          state_d = ST_WR_REQ;
        end
      end

      default: begin
        idx_d   = 2'd0;
        state_d = ST_WR_REQ;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WR_REQ;
      idx_q     <= 2'd0;
      cnt_q     <= 8'd0;
      rd_addr_q <= 5'd0;
      sample_q  <= 12'd0;
      sv_q      <= 1'b0;
      pend_q    <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      sample_q  <= sample_d;
      sv_q      <= sv_d;
      pend_q    <= pend_d;
      go_q      <= 1'b1;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sv_q;
  assign cfg_done     = (state_q == ST_RUN);
  assign err          = (state_q == ST_ERR);

endmodule
